// File: rtl/conv_window_ctrl.sv
// Sliding-window controller for a KxK convolution over a raster-scanned frame.
// Tracks the pixel position, gates line-buffer shifts and flags legal strided window positions.
module conv_window_ctrl #(
  parameter int IMAGE_WIDTH  = 32,
  parameter int IMAGE_HEIGHT = 32,
  parameter int KERNEL       = 3,
  parameter int STRIDE       = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            valid_in,
  output logic                            lb_enable,
  output logic                            busy,
  output logic                            window_valid,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  win_col,
  output logic                            frame_done
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_K    = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(KERNEL - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] col_r, col_s;
  logic [RW-1:0] row_r, row_s;
  logic [PW-1:0] col_ph_r, col_ph_s;
  logic [PW-1:0] row_ph_r, row_ph_s;
  logic [CW-1:0] out_col_r, out_col_s;
  logic [RW-1:0] out_row_r, out_row_s;
  logic          busy_r, frame_done_r, window_valid_r;
  logic [RW-1:0] win_row_r;
  logic [CW-1:0] win_col_r;

  logic accept_s, last_col_s, last_pix_s, fill_end_s, row_win_s, hit_s;

  assign accept_s   = valid_in && !reset && ((state_r == FILL) || (state_r == RUN));
  assign last_col_s = (col_r == COL_LAST);
  assign last_pix_s = last_col_s && (row_r == ROW_LAST);
  assign fill_end_s = (row_r == ROW_K) && (col_r == COL_K);
  // A window lands on this pixel when both axes are past the kernel edge and on a stride phase.
  assign row_win_s  = (row_r >= ROW_K) && (row_ph_r == {PW{1'b0}});
  assign hit_s      = row_win_s && (col_r >= COL_K) && (col_ph_r == {PW{1'b0}});

  assign lb_enable    = accept_s;
  assign busy         = busy_r;
  assign frame_done   = frame_done_r;
  assign window_valid = window_valid_r;
  assign win_row      = win_row_r;
  assign win_col      = win_col_r;

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = FILL;
        else       state_s = IDLE;
      end
      FILL: begin
        if (accept_s && last_pix_s)      state_s = DONE;
        else if (accept_s && fill_end_s) state_s = RUN;
        else                             state_s = FILL;
      end
      RUN: begin
        if (accept_s && last_pix_s) state_s = DONE;
        else                        state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the pixel, stride-phase and output-index counters.
  always_comb begin
    col_s     = col_r;
    row_s     = row_r;
    col_ph_s  = col_ph_r;
    row_ph_s  = row_ph_r;
    out_col_s = out_col_r;
    out_row_s = out_row_r;
    if ((state_r == IDLE) && start) begin
      col_s     = {CW{1'b0}};
      row_s     = {RW{1'b0}};
      col_ph_s  = {PW{1'b0}};
      row_ph_s  = {PW{1'b0}};
      out_col_s = {CW{1'b0}};
      out_row_s = {RW{1'b0}};
    end else if (accept_s) begin
      col_s = last_col_s ? {CW{1'b0}} : col_r + 1'b1;
      // Phase restarts at the kernel edge so phase 0 marks every S-th legal position.
      if (col_s == COL_K)
        col_ph_s = {PW{1'b0}};
      else if (col_r >= COL_K)
        col_ph_s = (col_ph_r == PH_LAST) ? {PW{1'b0}} : col_ph_r + 1'b1;
      else
        col_ph_s = {PW{1'b0}};

      if (last_col_s)
        out_col_s = {CW{1'b0}};
      else if (hit_s)
        out_col_s = out_col_r + 1'b1;
      else
        out_col_s = out_col_r;

      if (last_col_s) begin
        row_s = row_r + 1'b1;
        if (row_s == ROW_K)
          row_ph_s = {PW{1'b0}};
        else if (row_r >= ROW_K)
          row_ph_s = (row_ph_r == PH_LAST) ? {PW{1'b0}} : row_ph_r + 1'b1;
        else
          row_ph_s = {PW{1'b0}};
        out_row_s = row_win_s ? out_row_r + 1'b1 : out_row_r;
      end else begin
        row_s     = row_r;
        row_ph_s  = row_ph_r;
        out_row_s = out_row_r;
      end
    end else begin
      col_s = col_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r          <= {CW{1'b0}};
      row_r          <= {RW{1'b0}};
      col_ph_r       <= {PW{1'b0}};
      row_ph_r       <= {PW{1'b0}};
      out_col_r      <= {CW{1'b0}};
      out_row_r      <= {RW{1'b0}};
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
      window_valid_r <= 1'b0;
      win_row_r      <= {RW{1'b0}};
      win_col_r      <= {CW{1'b0}};
    end else begin
      col_r          <= col_s;
      row_r          <= row_s;
      col_ph_r       <= col_ph_s;
      row_ph_r       <= row_ph_s;
      out_col_r      <= out_col_s;
      out_row_r      <= out_row_s;
      busy_r         <= (state_s != IDLE);
      frame_done_r   <= (state_s == DONE);
      window_valid_r <= accept_s && hit_s;
      if (accept_s && hit_s) begin
        win_row_r <= out_row_r;
        win_col_r <= out_col_r;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: three parameterisations share one clock and reset,
// window positions and accept timing are checked against a hand-filled table.
module tb_conv_window_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic start_a [3];
  logic vin_a   [3];
  logic lb_a    [3];
  logic busy_a  [3];
  logic wv_a    [3];
  logic fd_a    [3];
  int   wr_a    [3];
  int   wc_a    [3];

  logic [1:0] wr0, wc0;
  logic [2:0] wr1, wc1;
  logic       wr2, wc2;

  assign wr_a[0] = int'(wr0);
  assign wc_a[0] = int'(wc0);
  assign wr_a[1] = int'(wr1);
  assign wc_a[1] = int'(wc1);
  assign wr_a[2] = int'(wr2);
  assign wc_a[2] = int'(wc2);

  conv_window_ctrl #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL(3), .STRIDE(1)) u_d0 (
    .clk(clk), .reset(reset), .start(start_a[0]), .valid_in(vin_a[0]),
    .lb_enable(lb_a[0]), .busy(busy_a[0]), .window_valid(wv_a[0]),
    .win_row(wr0), .win_col(wc0), .frame_done(fd_a[0]));

  conv_window_ctrl #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .KERNEL(3), .STRIDE(2)) u_d1 (
    .clk(clk), .reset(reset), .start(start_a[1]), .valid_in(vin_a[1]),
    .lb_enable(lb_a[1]), .busy(busy_a[1]), .window_valid(wv_a[1]),
    .win_row(wr1), .win_col(wc1), .frame_done(fd_a[1]));

  conv_window_ctrl #(.IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .KERNEL(1), .STRIDE(1)) u_d2 (
    .clk(clk), .reset(reset), .start(start_a[2]), .valid_in(vin_a[2]),
    .lb_enable(lb_a[2]), .busy(busy_a[2]), .window_valid(wv_a[2]),
    .win_row(wr2), .win_col(wc2), .frame_done(fd_a[2]));

  typedef struct {
    int row;
    int col;
    int acc;   // 1-based accept number after which the window appears
  } exp_t;

  exp_t tab [12];
  int   npix [3];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_frame(input int d, input int pat, input bit start_mid, input bit start_done);
    int  acc = 0;
    int  wins = 0;
    bit  last_v = 1'b0;
    bit  seen_done = 1'b0;
    bit  v;
    @(negedge clk);
    start_a[d] = 1'b1;
    vin_a[d]   = 1'b0;
    @(negedge clk);
    start_a[d] = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      v          = (pat == 0) ? 1'b1 : (cyc % 2 == 0);
      vin_a[d]   = v;
      start_a[d] = start_mid && (acc == 5);
      #1;
      chk($sformatf("d%0d lb_enable cyc%0d", d, cyc), int'(lb_a[d]), int'(v && acc < npix[d]));
      last_v = v && (acc < npix[d]);
      if (last_v) acc++;
      @(negedge clk);
      if (wv_a[d]) begin
        if (wins < 4) begin
          chk($sformatf("d%0d win%0d row", d, wins), wr_a[d], tab[d*4+wins].row);
          chk($sformatf("d%0d win%0d col", d, wins), wc_a[d], tab[d*4+wins].col);
          chk($sformatf("d%0d win%0d accept", d, wins), last_v ? acc : -1, tab[d*4+wins].acc);
        end else begin
          chk($sformatf("d%0d extra window", d), wins, 3);
        end
        wins++;
      end
      if (fd_a[d]) begin
        seen_done = 1'b1;
        chk($sformatf("d%0d done accept", d), last_v ? acc : -1, npix[d]);
        chk($sformatf("d%0d last window with done", d), int'(wv_a[d]), 1);
        chk($sformatf("d%0d busy in done", d), int'(busy_a[d]), 1);
      end
    end
    chk($sformatf("d%0d frame_done seen", d), int'(seen_done), 1);
    chk($sformatf("d%0d window count", d), wins, 4);
    // DONE cycle: valid_in must be ignored, and start too when requested
    vin_a[d]   = 1'b1;
    start_a[d] = start_done;
    #1;
    chk($sformatf("d%0d lb in done", d), int'(lb_a[d]), 0);
    @(negedge clk);
    start_a[d] = 1'b0;
    chk($sformatf("d%0d busy after done", d), int'(busy_a[d]), 0);
    chk($sformatf("d%0d done one cycle", d), int'(fd_a[d]), 0);
    chk($sformatf("d%0d wv after done", d), int'(wv_a[d]), 0);
    #1;
    chk($sformatf("d%0d lb idle", d), int'(lb_a[d]), 0);
    @(negedge clk);
    vin_a[d] = 1'b0;
    chk($sformatf("d%0d stays idle", d), int'(busy_a[d]), 0);
  endtask

  initial begin
    int bad;
    tab[0]  = '{0, 0, 11}; tab[1]  = '{0, 1, 12}; tab[2]  = '{1, 0, 15}; tab[3]  = '{1, 1, 16};
    tab[4]  = '{0, 0, 13}; tab[5]  = '{0, 1, 15}; tab[6]  = '{1, 0, 23}; tab[7]  = '{1, 1, 25};
    tab[8]  = '{0, 0, 1};  tab[9]  = '{0, 1, 2};  tab[10] = '{1, 0, 3};  tab[11] = '{1, 1, 4};
    npix[0] = 16; npix[1] = 25; npix[2] = 4;
    for (int d = 0; d < 3; d++) begin
      start_a[d] = 1'b0;
      vin_a[d]   = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("d%0d lb during reset", d), int'(lb_a[d]), 0);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d reset busy", d), int'(busy_a[d]), 0);
      chk($sformatf("d%0d reset wv", d), int'(wv_a[d]), 0);
      chk($sformatf("d%0d reset fd", d), int'(fd_a[d]), 0);
      chk($sformatf("d%0d reset win", d), wr_a[d] + wc_a[d], 0);
    end
    // valid_in while idle must not shift the line buffers
    for (int d = 0; d < 3; d++) begin
      vin_a[d] = 1'b1;
      #1;
      chk($sformatf("d%0d idle lb", d), int'(lb_a[d]), 0);
      @(negedge clk);
      chk($sformatf("d%0d idle busy", d), int'(busy_a[d]), 0);
      vin_a[d] = 1'b0;
    end

    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(1, 0, 1'b0, 1'b0);
    run_frame(0, 1, 1'b1, 1'b1);
    run_frame(2, 0, 1'b0, 1'b1);

    // Reset after the 9th accept aborts the frame
    @(negedge clk);
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    vin_a[0]   = 1'b1;
    repeat (9) @(negedge clk);
    chk("abort busy before reset", int'(busy_a[0]), 1);
    reset = 1'b1;
    #1;
    chk("abort lb in reset cycle", int'(lb_a[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (busy_a[0] || wv_a[0] || fd_a[0] || lb_a[0]) bad++;
      @(negedge clk);
    end
    chk("abort quiet cycles", bad, 0);
    vin_a[0] = 1'b0;
    run_frame(0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
